// File: rtl/mem_access_stage.sv
// mem_access_stage: pipeline memory stage. ALU ops pass through with no added latency.
// Loads and stores use a req/ack handshake and stall the pipe until ack or timeout.
module mem_access_stage #(
    parameter int TIMEOUT = 16
) (
    input  logic        clock,
    input  logic        clear,
    input  logic        in_valid,
    input  logic [15:0] alu_result,
    input  logic [15:0] store_data,
    input  logic [2:0]  Rdest_num,
    input  logic        Reg_write,
    input  logic        Mem_read,
    input  logic        Mem_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic [15:0] data,
    output logic [2:0]  Rdest_num_out,
    output logic        Reg_write_out,
    output logic        wb_valid,
    output logic        stall,
    output logic        mem_err
);
    typedef enum logic {IDLE, BUSY} state_t;
    state_t     state, state_nxt;
    logic [7:0] cnt;
    logic [2:0] rd_q;
    logic       rw_q;
    logic       mem_op, busy, done;
    assign mem_op = in_valid & (Mem_read | Mem_write);
    assign busy   = state == BUSY;
    assign done   = busy & (mem_ack | (cnt == 8'(TIMEOUT - 1)));
    always_comb begin
        state_nxt     = state;
        data          = 16'h0;
        Rdest_num_out = 3'd0;
        Reg_write_out = 1'b0;
        wb_valid      = 1'b0;
        stall         = 1'b0;
        if (!clear && !busy) begin
            stall         = mem_op;
            state_nxt     = mem_op ? BUSY : IDLE;
            data          = mem_op ? 16'h0 : alu_result;
            Rdest_num_out = mem_op ? 3'd0 : Rdest_num;
            Reg_write_out = ~mem_op & Reg_write & in_valid;
            wb_valid      = ~mem_op & in_valid;
        end else if (!clear) begin
            stall         = ~done;
            wb_valid      = done;
            state_nxt     = done ? IDLE : BUSY;
            // mem_we doubles as the captured is_store flag; a timeout leaves data and write-enable at zero
            data          = mem_ack ? (mem_we ? mem_addr : mem_rdata) : 16'h0;
            Rdest_num_out = mem_ack ? rd_q : 3'd0;
            Reg_write_out = mem_ack & rw_q & ~mem_we;
        end
    end
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= 16'h0;
            mem_wdata <= 16'h0;
            cnt       <= 8'd0;
            mem_err   <= 1'b0;
            rd_q      <= 3'd0;
            rw_q      <= 1'b0;
        end else begin
            state <= state_nxt;
            if (!busy && mem_op) begin
                mem_req   <= 1'b1;
                mem_we    <= Mem_write;
                mem_addr  <= alu_result;
                mem_wdata <= store_data;
                rd_q      <= Rdest_num;
                rw_q      <= Reg_write;
                cnt       <= 8'd0;
            end else if (done) begin
                mem_req <= 1'b0;
                if (!mem_ack) mem_err <= 1'b1;
            end else if (busy) begin
                cnt <= cnt + 8'd1;
            end
        end
    end
endmodule
